// File: rtl/csa_multi_fault_sel_gen.sv
// Self-test and spare-steering controller for N redundant W-bit CSA multiplier copies.
// A run streams NVEC vectors, compares every copy against the golden result and accumulates a
// sticky per-unit fault map. It then assigns the L = N-S logical lanes to healthy units in
// ascending unit order.
// Optional feature macro: FIRST_FAIL_LOG_EN adds first_fail / fail_seen per-unit failure logs.

module csa_multi_fault_sel_gen #(
  parameter int unsigned W    = 6,
  parameter int unsigned N    = 5,
  parameter int unsigned S    = 2,
  parameter int unsigned NVEC = 16,
  localparam int unsigned IW  = (N > 1) ? $clog2(N) : 1,
  localparam int unsigned L   = N - S,
  localparam int unsigned VW  = (NVEC > 1) ? $clog2(NVEC) : 1,
  localparam int unsigned CW  = $clog2(N + 1)
) (
  input  logic              clk,
  input  logic              init_n,
  input  logic              start,
  input  logic              clr,
  input  logic              vec_valid,
  input  logic [N*W-1:0]    actual_output,
  input  logic [W-1:0]      desired_output,
  output logic              vec_ready,
  output logic [VW-1:0]     vec_idx,
  output logic              busy,
  output logic              done,
  output logic              sel_valid,
  output logic [L*IW-1:0]   sel,
  output logic [N-1:0]      fault_map,
`ifdef FIRST_FAIL_LOG_EN
  output logic [N*VW-1:0]   first_fail,
  output logic [N-1:0]      fail_seen,
`endif
  output logic [CW-1:0]     fault_cnt,
  output logic              uncorrectable
);

  typedef enum logic [1:0] {StIdle, StTest, StAlloc, StDone} state_e;

  localparam logic [VW-1:0] VecLast  = VW'(NVEC - 1);
  localparam logic [IW-1:0] UnitLast = IW'(N - 1);
  localparam logic [IW-1:0] LanesW   = IW'(L);
  localparam logic [CW-1:0] SparesW  = CW'(S);

  state_e          state_q;
  logic [IW-1:0]   unit_q;
  logic [IW-1:0]   lane_q;
  logic [N-1:0]    comp;
  logic [CW-1:0]   pop;

  // Per-unit mismatch flags against the golden result
  always_comb begin
    comp = '0;
    for (int unsigned k = 0; k < N; k++) begin
      comp[k] = |(actual_output[k*W +: W] ^ desired_output);
    end
  end

  // Number of faulty units in the current map
  always_comb begin
    pop = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pop = pop + CW'(fault_map[k]);
    end
  end

  // Status outputs decoded straight from the state register
  always_comb begin
    vec_ready = (state_q == StTest);
    busy      = (state_q == StTest) || (state_q == StAlloc);
    done      = (state_q == StDone);
  end

  // Controller: test sequencing, fault accumulation, lane allocation and result registers
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_q       <= StIdle;
      unit_q        <= '0;
      lane_q        <= '0;
      vec_idx       <= '0;
      sel_valid     <= 1'b0;
      fault_map     <= '0;
      fault_cnt     <= '0;
      uncorrectable <= 1'b0;
      for (int unsigned l = 0; l < L; l++) begin
        sel[l*IW +: IW] <= IW'(l);
      end
`ifdef FIRST_FAIL_LOG_EN
      first_fail    <= '0;
      fail_seen     <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          // clr and start on the same edge: map cleared, run begins from an empty map
          if (clr) begin
            fault_map  <= '0;
`ifdef FIRST_FAIL_LOG_EN
            first_fail <= '0;
            fail_seen  <= '0;
`endif
          end
          if (start) begin
            state_q   <= StTest;
            vec_idx   <= '0;
            sel_valid <= 1'b0;
          end
        end
        StTest: begin
          // vec_valid low is a stall: nothing moves
          if (vec_valid) begin
            fault_map <= fault_map | comp;
`ifdef FIRST_FAIL_LOG_EN
            for (int unsigned k = 0; k < N; k++) begin
              if (comp[k] && !fail_seen[k]) begin
                fail_seen[k]             <= 1'b1;
                first_fail[k*VW +: VW]   <= vec_idx;
              end
            end
`endif
            if (vec_idx == VecLast) begin
              vec_idx <= '0;
              state_q <= StAlloc;
              unit_q  <= '0;
              lane_q  <= '0;
              // Lanes left unfilled by the allocation pass stay at unit 0
              sel     <= '0;
            end else begin
              vec_idx <= vec_idx + VW'(1);
            end
          end
        end
        StAlloc: begin
          // One unit examined per cycle; healthy units fill lanes in ascending order
          if (!fault_map[unit_q] && (lane_q < LanesW)) begin
            sel[lane_q*IW +: IW] <= unit_q;
            lane_q               <= lane_q + IW'(1);
          end
          if (unit_q == UnitLast) begin
            state_q <= StDone;
          end else begin
            unit_q <= unit_q + IW'(1);
          end
        end
        StDone: begin
          sel_valid     <= 1'b1;
          fault_cnt     <= pop;
          uncorrectable <= (pop > SparesW);
          state_q       <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
